// File: rtl/ram_dump.sv
// Streams a full BRAM image out over a valid/ready port, one word per READ/WAIT/SEND pass.
// Define RAM_DUMP_CHECKSUM_EN to append a modulo-2^NB_DATA sum of all words as a final beat.

// state | meaning
// IDLE  | waiting for in_start while the logging BRAM reports full
// READ  | present current address to the BRAM
// WAIT  | BRAM output valid, capture it into the output register
// SEND  | offer the captured word until the consumer accepts it
// CSUM  | offer the running sum (checksum build only)
// DONE  | one-cycle completion pulse, rewind the address
module ram_dump #(
    parameter int NB_DATA = 16,
    parameter int NB_ADDR = 10
) (
    input  logic               clock,
    input  logic               cpu_reset,
    input  logic               in_start,
    input  logic               in_full_from_ram,
    input  logic [NB_DATA-1:0] in_data_from_ram,
    output logic [NB_ADDR-1:0] out_ram_read_addr,
    output logic [NB_DATA-1:0] out_data,
    output logic               out_valid,
    input  logic               in_ready,
    output logic               out_busy,
    output logic               out_done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_SEND,
`ifdef RAM_DUMP_CHECKSUM_EN
        ST_CSUM,
`endif
        ST_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [NB_ADDR-1:0] r_addr;
    logic [NB_ADDR-1:0] w_next_addr;
    logic [NB_DATA-1:0] r_data;
    logic [NB_DATA-1:0] w_next_data;
    logic               w_last;

    assign w_last = &r_addr;

`ifdef RAM_DUMP_CHECKSUM_EN
    logic [NB_DATA-1:0] r_sum;
    logic [NB_DATA-1:0] w_next_sum;

    always_ff @(posedge clock or posedge cpu_reset) begin
        if (cpu_reset) begin
            r_sum <= '0;
        end else begin
            r_sum <= w_next_sum;
        end
    end

    // Sum restarts only when a new dump is accepted, and grows on each data transfer.
    always_comb begin
        w_next_sum = r_sum;
        if (r_state == ST_IDLE && in_start && in_full_from_ram) begin
            w_next_sum = '0;
        end else if (r_state == ST_SEND && in_ready) begin
            w_next_sum = r_sum + r_data;
        end
    end
`endif

    always_ff @(posedge clock or posedge cpu_reset) begin
        if (cpu_reset) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_next_state;
            r_addr  <= w_next_addr;
            r_data  <= w_next_data;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_addr  = r_addr;
        w_next_data  = r_data;
        case (r_state)
            ST_IDLE: begin
                if (in_start && in_full_from_ram) begin
                    w_next_state = ST_READ;
                end
            end
            ST_READ: begin
                w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                w_next_data  = in_data_from_ram;
                w_next_state = ST_SEND;
            end
            ST_SEND: begin
                if (in_ready) begin
                    w_next_addr = r_addr + 1'b1;
                    if (w_last) begin
`ifdef RAM_DUMP_CHECKSUM_EN
                        w_next_state = ST_CSUM;
`else
                        w_next_state = ST_DONE;
`endif
                    end else begin
                        w_next_state = ST_READ;
                    end
                end
            end
`ifdef RAM_DUMP_CHECKSUM_EN
            ST_CSUM: begin
                if (in_ready) begin
                    w_next_state = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                w_next_addr  = '0;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_addr  = '0;
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign out_ram_read_addr = r_addr;
    assign out_busy          = (r_state != ST_IDLE);
    assign out_done          = (r_state == ST_DONE);

`ifdef RAM_DUMP_CHECKSUM_EN
    assign out_valid = (r_state == ST_SEND) || (r_state == ST_CSUM);
    assign out_data  = (r_state == ST_CSUM) ? r_sum : r_data;
`else
    assign out_valid = (r_state == ST_SEND);
    assign out_data  = r_data;
`endif

endmodule

// File: tb/tb_ram_dump.sv
// Directed bench for ram_dump: BRAM model with one-cycle read latency and a scoreboard
// of expected words filled at each start and drained on every valid/ready transfer.
module tb_ram_dump;

    localparam int NB_DATA = 16;
    localparam int NB_ADDR = 10;
    localparam int DEPTH   = 1 << NB_ADDR;
`ifdef RAM_DUMP_CHECKSUM_EN
    localparam int NCS = 1;
`else
    localparam int NCS = 0;
`endif

    logic               clock = 1'b0;
    logic               cpu_reset;
    logic               in_start;
    logic               in_full_from_ram;
    logic [NB_DATA-1:0] in_data_from_ram;
    logic [NB_ADDR-1:0] out_ram_read_addr;
    logic [NB_DATA-1:0] out_data;
    logic               out_valid;
    logic               in_ready;
    logic               out_busy;
    logic               out_done;

    logic [NB_DATA-1:0] mem [DEPTH];
    logic [NB_DATA-1:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    ram_dump #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) dut (
        .clock            (clock),
        .cpu_reset        (cpu_reset),
        .in_start         (in_start),
        .in_full_from_ram (in_full_from_ram),
        .in_data_from_ram (in_data_from_ram),
        .out_ram_read_addr(out_ram_read_addr),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .in_ready         (in_ready),
        .out_busy         (out_busy),
        .out_done         (out_done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) in_data_from_ram <= mem[out_ram_read_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"},  {31'd0, out_busy},  32'd0);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_done"},  {31'd0, out_done},  32'd0);
        check({tag, "_data"},  {16'd0, out_data},  32'd0);
        check({tag, "_addr"},  {22'd0, out_ram_read_addr}, 32'd0);
    endtask

    // One complete dump. Negative *_at arguments disable that disturbance.
    task automatic dump(input int stall_at, input int start_at, input int drop_at,
                        input int reset_at, output int words, output int busy_cyc,
                        output int dones);
        int stall_left;
        logic [NB_DATA-1:0] sum;
        stall_left = 50;
        sum = '0;
        words = 0;
        busy_cyc = 0;
        dones = 0;
        @(negedge clock);
        check("idle_before_start", {31'd0, out_busy}, 32'd0);
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) begin
            exp_q.push_back(mem[i]);
            sum += mem[i];
        end
`ifdef RAM_DUMP_CHECKSUM_EN
        exp_q.push_back(sum);
`endif
        in_start = 1'b1;
        in_full_from_ram = 1'b1;
        in_ready = 1'b1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clock);
            in_start = 1'b0;
            if (out_busy) busy_cyc++;
            if (out_done) begin
                dones++;
                check("done_valid_low", {31'd0, out_valid}, 32'd0);
                break;
            end
            if (out_valid) begin
                if (words == start_at) in_start = 1'b1;
                if (words == drop_at) in_full_from_ram = 1'b0;
                if (words == reset_at) begin
                    cpu_reset = 1'b1;
                    #1;
                    check_zero_outputs("async_reset");
                    return;
                end
                if (words == stall_at && stall_left > 0) begin
                    in_ready = 1'b0;
                    stall_left--;
                    check("stall_valid", {31'd0, out_valid}, 32'd1);
                    check("stall_data", {16'd0, out_data}, {16'd0, exp_q[0]});
                end else begin
                    in_ready = 1'b1;
                    check($sformatf("word%0d", words), {16'd0, out_data}, {16'd0, exp_q.pop_front()});
                    if (words < DEPTH) begin
                        check($sformatf("addr%0d", words), {22'd0, out_ram_read_addr}, words);
                    end
                    words++;
                end
            end else begin
                in_ready = (cyc % 2 == 0);
            end
        end
        check("done_seen", dones, 1);
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        int w;
        int b;
        int d;
        cpu_reset = 1'b1;
        in_start = 1'b0;
        in_full_from_ram = 1'b0;
        in_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = NB_DATA'(i);
        repeat (2) @(negedge clock);
        check_zero_outputs("reset");
        cpu_reset = 1'b0;

        // start without full: must stay idle
        @(negedge clock);
        in_start = 1'b1;
        in_full_from_ram = 1'b0;
        in_ready = 1'b1;
        repeat (5) begin
            @(negedge clock);
            check("nofull_busy", {31'd0, out_busy}, 32'd0);
            check("nofull_addr", {22'd0, out_ram_read_addr}, 32'd0);
            check("nofull_valid", {31'd0, out_valid}, 32'd0);
        end
        in_start = 1'b0;

        // clean dump, ready always high
        dump(-1, -1, -1, -1, w, b, d);
        check("clean_words", w, DEPTH + NCS);
        check("clean_busy_cycles", b, 3 * DEPTH + NCS + 1);
        @(negedge clock);
        check("clean_busy_fall", {31'd0, out_busy}, 32'd0);
        check("clean_done_once", {31'd0, out_done}, 32'd0);

        // ready stall at word 5
        dump(5, -1, -1, -1, w, b, d);
        check("stall_words", w, DEPTH + NCS);

        // extra start at word 100, full drop at word 200
        dump(-1, 100, 200, -1, w, b, d);
        check("disturb_words", w, DEPTH + NCS);
        check("disturb_dones", d, 1);
        @(negedge clock);
        check("disturb_no_restart", {31'd0, out_busy}, 32'd0);

        // async reset at word 300, then restart from 0
        dump(-1, -1, -1, 300, w, b, d);
        @(negedge clock);
        cpu_reset = 1'b0;
        repeat (3) begin
            @(negedge clock);
            check("post_reset_idle", {31'd0, out_busy}, 32'd0);
        end
        dump(-1, -1, -1, -1, w, b, d);
        check("restart_words", w, DEPTH + NCS);

        // back-to-back dumps over a random image
        for (int i = 0; i < DEPTH; i++) mem[i] = NB_DATA'($urandom);
        dump(-1, -1, -1, -1, w, b, d);
        check("b2b_first_words", w, DEPTH + NCS);
        dump(-1, -1, -1, -1, w, b, d);
        check("b2b_second_words", w, DEPTH + NCS);
        check("b2b_second_cycles", b, 3 * DEPTH + NCS + 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
